// File: rtl/jpeg_mcu_block_sequencer.sv
// Ping-pong 8x8 block buffer that turns NUM_CH-wide raster pixels into a
// channel-serial sample stream (all of ch0, then ch1, ...) for one shared
// JPEG encoder core. Gray blocks emit only channel 0.
module jpeg_mcu_block_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 8,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_last,
  input  logic                     gray_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               out_ch,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     out_mcu_last,
  output logic                     err_framing
);

  typedef enum logic {
    RD_IDLE,
    RD_EMIT
  } rd_state_t;

  localparam logic [1:0]        LAST_CH    = 2'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] SHIFT_MASK =
    (LEVEL_SHIFT != 0) ? (DATA_W'(1) << (DATA_W - 1)) : '0;

  logic [DATA_W-1:0] mem [2][NUM_CH][64];

  logic [1:0] full_q, full_d;
  logic [1:0] gray_q, gray_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [5:0] wr_idx_q, wr_idx_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  logic [1:0] rd_ch_q, rd_ch_d;
  logic       gray_cur_q, gray_cur_d;
  logic       err_q, err_d;
  rd_state_t  rd_state_q, rd_state_d;

  logic              in_acc;
  logic              rd_acc;
  logic [1:0]        last_ch;
  logic [DATA_W-1:0] sample;

  assign in_ready = !full_q[wr_bank_q];
  assign in_acc   = in_valid && in_ready;
  assign rd_acc   = out_valid && out_ready;
  assign last_ch  = gray_q[rd_bank_q] ? 2'd0 : LAST_CH;

  // Pixel storage: every channel of an accepted pixel lands at wr_idx.
  // NOTE: the sample array has no reset; the full flags gate every read, so
  // stale contents are never observable and the flops stay reset-free.
  always_ff @(posedge clock) begin
    if (in_acc) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[wr_bank_q][c][wr_idx_q] <= in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Control state register with synchronous reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed by the next-state logic, regardless of order.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q     <= '0;
      gray_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      rd_ch_q    <= '0;
      gray_cur_q <= 1'b0;
      err_q      <= 1'b0;
      rd_state_q <= RD_IDLE;
    end else begin
      full_q     <= full_d;
      gray_q     <= gray_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      rd_ch_q    <= rd_ch_d;
      gray_cur_q <= gray_cur_d;
      err_q      <= err_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Next-state logic for the write counter, bank flags and read walker.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    full_d     = full_q;
    gray_d     = gray_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    rd_ch_d    = rd_ch_q;
    gray_cur_d = gray_cur_q;
    err_d      = 1'b0;

    if (in_acc) begin
      if (wr_idx_q == 6'd63) begin
        // Block complete; a missing in_last is flagged but not fatal.
        full_d[wr_bank_q] = 1'b1;
        gray_d[wr_bank_q] = gray_cur_q;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
        err_d             = !in_last;
      end else if (in_last) begin
        // Early in_last: drop the partial block, bank stays empty.
        wr_idx_d = '0;
        err_d    = 1'b1;
      end else begin
        if (wr_idx_q == 6'd0) gray_cur_d = gray_mode;
        wr_idx_d = wr_idx_q + 6'd1;
      end
    end

    // Write only sets a flag on an empty bank and read only clears a full
    // one, so the two updates can never target the same bit in one cycle.
    if (rd_acc) begin
      if (rd_idx_q == 6'd63) begin
        rd_idx_d = '0;
        if (rd_ch_q == last_ch) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          rd_ch_d           = '0;
        end else begin
          rd_ch_d = rd_ch_q + 2'd1;
        end
      end else begin
        rd_idx_d = rd_idx_q + 6'd1;
      end
    end

    // Registered mirror of full[rd_bank] so out_valid has no extra latency.
    rd_state_d = full_d[rd_bank_d] ? RD_EMIT : RD_IDLE;
  end

  // Output stage: combinational read mux plus per-sample framing flags.
  always_comb begin
    sample       = mem[rd_bank_q][rd_ch_q][rd_idx_q];
    out_valid    = (rd_state_q == RD_EMIT);
    out_data     = out_valid ? (sample ^ SHIFT_MASK) : '0;
    out_ch       = rd_ch_q;
    out_first    = out_valid && (rd_idx_q == 6'd0);
    out_last     = out_valid && (rd_idx_q == 6'd63);
    out_mcu_last = out_last && (rd_ch_q == last_ch);
    err_framing  = err_q;
  end

endmodule

// File: tb/tb_jpeg_mcu_block_sequencer.sv
// Scoreboard bench: the driver pushes expected samples as blocks are issued,
// a negedge monitor pops and compares on every output handshake. A second
// instance with level shift shares all inputs and is checked against the
// same expectations with the MSB flipped.
module tb_jpeg_mcu_block_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
    logic       first;
    logic       last;
    logic       mcu_last;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_last;
  logic        gray_mode;
  logic        out_ready;

  logic       rdy0, ov0, of0, ol0, oml0, ef0;
  logic       rdy1, ov1, of1, ol1, oml1, ef1;
  logic [7:0] od0, od1;
  logic [1:0] och0, och1;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   pop_count = 0;
  int   err_pulses = 0;

  always #5 clock = ~clock;

  jpeg_mcu_block_sequencer #(.NUM_CH(3), .DATA_W(8), .LEVEL_SHIFT(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .gray_mode(gray_mode),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ch(och0),
    .out_first(of0), .out_last(ol0), .out_mcu_last(oml0), .err_framing(ef0)
  );

  jpeg_mcu_block_sequencer #(.NUM_CH(3), .DATA_W(8), .LEVEL_SHIFT(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .gray_mode(gray_mode),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ch(och1),
    .out_first(of1), .out_last(ol1), .out_mcu_last(oml1), .err_framing(ef1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Pattern 0: ramps; 1: ch0 alternates 0x00/0xFF; 2: mixed arithmetic.
  function automatic logic [7:0] pix(input int pat, input int c, input int i);
    case (pat)
      0:       return (c == 0) ? 8'(i) : (c == 1) ? 8'(64 + i) : 8'(128 + i);
      1:       return (c == 0) ? ((i % 2) ? 8'hFF : 8'h00) : (c == 1) ? 8'(255 - i) : 8'(3 * i);
      default: return (c == 0) ? 8'(i * 5 + 7) : (c == 1) ? 8'(i ^ 165) : 8'(200 - i);
    endcase
  endfunction

  task automatic push_block(input int pat, input bit gray);
    int nch;
    exp_t e;
    nch = gray ? 1 : 3;
    for (int c = 0; c < nch; c++) begin
      for (int i = 0; i < 64; i++) begin
        e.data     = pix(pat, c, i);
        e.ch       = 2'(c);
        e.first    = (i == 0);
        e.last     = (i == 63);
        e.mcu_last = (i == 63) && (c == nch - 1);
        q.push_back(e);
      end
    end
  endtask

  // Holds one pixel until accepted; in_ready is sampled on the negedge.
  task automatic send_pixel(input logic [23:0] d, input logic last, input logic gray);
    logic acc;
    int   n;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    gray_mode = gray;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 3000) begin
      @(negedge clock);
      acc = rdy0;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: pixel not accepted after %0d cycles, required accept", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_block(input int pat, input bit gray_first, input bit gray_rest,
                            input bit mark_last, input bit do_push);
    if (do_push) push_block(pat, gray_first);
    for (int i = 0; i < 64; i++) begin
      send_pixel({pix(pat, 2, i), pix(pat, 1, i), pix(pat, 0, i)},
                 (i == 63) && mark_last, (i == 0) ? gray_first : gray_rest);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ov0) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_remaining", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare every handshaked sample against the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (ef0) err_pulses++;
      if (ov0 && out_ready) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_sample: got data 0x%0h ch %0d, expected no sample", od0, och0);
        end else begin
          e = q.pop_front();
          check("sample{data,ch,first,last,mcu}", {od0, och0, of0, ol0, oml0}, e);
          check("ls_data", od1, e.data ^ 8'h80);
          check("ls_valid", ov1, 1'b1);
        end
        pop_count++;
      end
    end
  end

  initial begin
    int base;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    gray_mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", rdy0, 1'b1);
    check("rst_out_valid", ov0, 1'b0);
    check("rst_out_data", od0, 8'h00);
    check("rst_ls_out_data", od1, 8'h00);
    check("rst_out_ch", och0, 2'd0);
    check("rst_flags", {of0, ol0, oml0, ef0}, 4'b0000);

    // Ramp block, streamed Y, Cb, Cr
    send_block(0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // 0x00/0xFF on luma exercises the level-shift extremes
    send_block(1, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // Stall output, fill both banks, then release
    out_ready = 1'b0;
    send_block(0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_block(2, 1'b0, 1'b0, 1'b1, 1'b1);
    check("both_full_in_ready", rdy0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("both_full_hold_in_ready", rdy0, 1'b0);
    check("stalled_queue", 32'(q.size()), 32'd384);
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("no_bubble_cycles", 32'(n), 32'd384);
    wait_drain();

    // Gray latched on first pixel: A gray (toggled off mid-block), B colour
    send_block(1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_block(2, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Early in_last at pixel 10: dropped with an error pulse
    base = err_pulses;
    for (int i = 0; i < 10; i++) begin
      send_pixel({pix(2, 2, i), pix(2, 1, i), pix(2, 0, i)}, i == 9, 1'b0);
    end
    repeat (5) @(posedge clock);
    #1;
    check("early_last_err_pulses", 32'(err_pulses - base), 32'd1);
    check("early_last_no_valid", ov0, 1'b0);
    check("early_last_in_ready", rdy0, 1'b1);
    send_block(2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // Missing in_last at pixel 63: block still emitted, error pulse
    base = err_pulses;
    send_block(0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check("missing_last_err_pulses", 32'(err_pulses - base), 32'd1);

    // Reset after 70 output samples, then a fresh block from Y0
    send_block(0, 1'b0, 1'b0, 1'b1, 1'b1);
    base = pop_count;
    n = 0;
    while (pop_count - base < 70 && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("mid_reset_samples_before", 32'(pop_count - base), 32'd70);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_reset_out_valid", ov0, 1'b0);
    check("mid_reset_in_ready", rdy0, 1'b1);
    check("mid_reset_out_ch", och0, 2'd0);
    check("mid_reset_out_data", od0, 8'h00);
    q.delete();
    send_block(2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
